// File: rtl/blake2s_pkg.sv
// Shared constants and types for the BLAKE2s message feeder and core wrapper.
package blake2s_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int BLOCK_W     = 512;
    localparam int LEN_W       = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_GAP
    } feeder_state_e;

    typedef struct packed {
        logic               init;
        logic               next;
        logic               is_final;
        logic [BLOCK_W-1:0] block;
        logic [LEN_W-1:0]   length;
    } core_cmd_t;

endpackage

// File: rtl/blake2s_block_buf.sv
// 64-byte block register with indexed byte write, clear/load, and fill index.
module blake2s_block_buf #(
    parameter int BLOCK_BYTES = 64,
    localparam int IDX_W = $clog2(BLOCK_BYTES)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     load,
    input  logic [BLOCK_BYTES*8-1:0] load_data,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic [BLOCK_BYTES*8-1:0] data,
    output logic [IDX_W-1:0]         idx,
    output logic                     full
);

    // full means the byte written at the current index completes the block
    assign full = (idx == IDX_W'(BLOCK_BYTES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
            idx  <= '0;
        end else if (load) begin
            data <= load_data;
            idx  <= '0;
        end else if (clear) begin
            data <= '0;
            idx  <= '0;
        end else if (wr_en) begin
            data[int'(idx)*8 +: 8] <= wr_data;
            idx                    <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/blake2s_msg_feeder.sv
// Packs a byte-serial message into BLAKE2s blocks and issues init/next/final to the core.
// Optional keyed mode (key block sent first) is enabled with BLAKE2_FEEDER_KEY_EN.
module blake2s_msg_feeder #(
    parameter int BLOCK_BYTES = 64,
    parameter int LEN_W       = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     msg_empty,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic                     core_ready,
    output logic                     core_init,
    output logic                     core_next,
    output logic                     core_final,
    output logic [BLOCK_BYTES*8-1:0] core_block,
    output logic [LEN_W-1:0]         core_length,
    output logic                     busy
`ifdef BLAKE2_FEEDER_KEY_EN
    ,
    input  logic [255:0]             key,
    input  logic [5:0]               key_len
`endif
);

    import blake2s_pkg::*;

    localparam int IDX_W = $clog2(BLOCK_BYTES);

    feeder_state_e            state;
    logic                     first_blk;
    logic                     last;
    logic [LEN_W-1:0]         length;
    logic                     keyed;
    logic [BLOCK_BYTES*8-1:0] key_block;
    logic [BLOCK_BYTES*8-1:0] blk_data;
    logic [IDX_W-1:0]         blk_idx;
    logic                     blk_full;
    logic                     blk_clear;
    logic                     blk_load;
    logic                     wr_en;
    logic                     fire;

`ifdef BLAKE2_FEEDER_KEY_EN
    logic [5:0] klen;

    assign klen  = (key_len > 6'd32) ? 6'd32 : key_len;
    assign keyed = (key_len != 6'd0);

    always_comb begin
        key_block = '0;
        for (int i = 0; i < 32; i++) begin
            if (6'(i) < klen) key_block[i*8 +: 8] = key[i*8 +: 8];
        end
    end
`else
    assign keyed     = 1'b0;
    assign key_block = '0;
`endif

    assign wr_en     = (state == ST_FILL) && in_valid;
    assign blk_load  = (state == ST_IDLE) && start && keyed;
    // Each new block starts from zeros so the tail of a short block is already padded
    assign blk_clear = ((state == ST_IDLE) && start && !keyed) ||
                       ((state == ST_GAP) && !last);

    blake2s_block_buf #(
        .BLOCK_BYTES(BLOCK_BYTES)
    ) u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (blk_clear),
        .load     (blk_load),
        .load_data(key_block),
        .wr_en    (wr_en),
        .wr_data  (in_data),
        .data     (blk_data),
        .idx      (blk_idx),
        .full     (blk_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            first_blk <= 1'b0;
            last      <= 1'b0;
            length    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        first_blk <= 1'b1;
                        if (keyed) begin
                            length <= LEN_W'(BLOCK_BYTES);
                            last   <= msg_empty;
                            state  <= ST_ISSUE;
                        end else if (msg_empty) begin
                            length <= '0;
                            last   <= 1'b1;
                            state  <= ST_ISSUE;
                        end else begin
                            length <= '0;
                            last   <= 1'b0;
                            state  <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (in_valid) begin
                        length <= length + LEN_W'(1);
                        if (in_last || blk_full) begin
                            last  <= in_last;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (core_ready) begin
                        first_blk <= 1'b0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= last ? ST_IDLE : ST_FILL;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Command is decoded from registered state so it fires in the first core_ready cycle
    assign fire        = (state == ST_ISSUE) && core_ready;
    assign core_init   = fire && first_blk;
    assign core_next   = fire && !first_blk;
    assign core_final  = fire && last;
    assign core_block  = blk_data;
    assign core_length = length;
    assign in_ready    = (state == ST_FILL);
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_blake2s_msg_feeder.sv
// Directed self-checking bench for blake2s_msg_feeder (default, unkeyed build).
module tb_blake2s_msg_feeder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         msg_empty;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         core_ready;
    logic         core_init;
    logic         core_next;
    logic         core_final;
    logic [511:0] core_block;
    logic [63:0]  core_length;
    logic         busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic         init;
        logic         next;
        logic         fin;
        logic [511:0] blk;
        logic [63:0]  len;
    } cmd_t;

    cmd_t cmds[$];

    blake2s_msg_feeder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .msg_empty  (msg_empty),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .core_ready (core_ready),
        .core_init  (core_init),
        .core_next  (core_next),
        .core_final (core_final),
        .core_block (core_block),
        .core_length(core_length),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_init || core_next) begin
            cmds.push_back('{core_init, core_next, core_final, core_block, core_length});
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic empty);
        step();
        start     = 1'b1;
        msg_empty = empty;
        step();
        start     = 1'b0;
        msg_empty = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic check_cmd(input string tag, input int k, input logic i, input logic nx,
                             input logic f, input logic [511:0] b, input logic [63:0] len);
        if (cmds.size() > k) begin
            check({tag, "_init"},  cmds[k].init, i);
            check({tag, "_next"},  cmds[k].next, nx);
            check({tag, "_final"}, cmds[k].fin, f);
            check({tag, "_block"}, cmds[k].blk, b);
            check({tag, "_len"},   cmds[k].len, len);
        end else begin
            check({tag, "_missing"}, 512'(cmds.size()), 512'(k + 1));
        end
    endtask

    logic [511:0] exp_blk;

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        msg_empty  = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        core_ready = 1'b1;
        step();
        step();
        step();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_init", core_init, 1'b0);
        check("rst_next", core_next, 1'b0);
        check("rst_final", core_final, 1'b0);
        check("rst_block", core_block, 512'h0);
        check("rst_len", core_length, 64'h0);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        step();

        // "abc"
        cmds.delete();
        do_start(1'b0);
        check("abc_busy", busy, 1'b1);
        check("abc_in_ready", in_ready, 1'b1);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        wait_idle("abc_idle");
        check("abc_count", 512'(cmds.size()), 512'd1);
        check_cmd("abc", 0, 1'b1, 1'b0, 1'b1, 512'h636261, 64'd3);

        // start while idle-ignored in_valid: bytes outside FILL have no effect
        in_valid = 1'b1;
        in_last  = 1'b1;
        step();
        step();
        check("idle_ignore_busy", busy, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;

        // exactly 64 bytes, last on byte 63
        cmds.delete();
        exp_blk = '0;
        for (int i = 0; i < 64; i++) exp_blk[i*8 +: 8] = 8'(i);
        do_start(1'b0);
        for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63);
        wait_idle("b64_idle");
        repeat (3) step();
        check("b64_count", 512'(cmds.size()), 512'd1);
        check_cmd("b64", 0, 1'b1, 1'b0, 1'b1, exp_blk, 64'd64);

        // 65 bytes: full block then a one-byte final block
        cmds.delete();
        do_start(1'b0);
        for (int i = 0; i < 65; i++) send_byte(8'(i), i == 64);
        wait_idle("b65_idle");
        check("b65_count", 512'(cmds.size()), 512'd2);
        check_cmd("b65_first", 0, 1'b1, 1'b0, 1'b0, exp_blk, 64'd64);
        check_cmd("b65_second", 1, 1'b0, 1'b1, 1'b1, 512'h40, 64'd65);

        // empty message
        cmds.delete();
        do_start(1'b1);
        wait_idle("empty_idle");
        check("empty_count", 512'(cmds.size()), 512'd1);
        check_cmd("empty", 0, 1'b1, 1'b0, 1'b1, 512'h0, 64'd0);

        // core_ready held low in ISSUE
        cmds.delete();
        do_start(1'b0);
        send_byte(8'h11, 1'b0);
        core_ready = 1'b0;
        send_byte(8'h22, 1'b1);
        for (int c = 0; c < 10; c++) begin
            check("hold_no_init", core_init, 1'b0);
            check("hold_no_next", core_next, 1'b0);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_block", core_block, 512'h2211);
            check("hold_len", core_length, 64'd2);
            step();
        end
        core_ready = 1'b1;
        #1;
        check("hold_release_init", core_init, 1'b1);
        check("hold_release_final", core_final, 1'b1);
        wait_idle("hold_idle");
        check("hold_count", 512'(cmds.size()), 512'd1);

        // reset mid-message, then a clean "abc"
        cmds.delete();
        do_start(1'b0);
        for (int i = 0; i < 30; i++) send_byte(8'hAA, 1'b0);
        check("mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_len", core_length, 64'h0);
        check("mid_rst_block", core_block, 512'h0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_init", core_init, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        check("mid_rst_nocmd", 512'(cmds.size()), 512'd0);
        do_start(1'b0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        wait_idle("post_rst_idle");
        check("post_rst_count", 512'(cmds.size()), 512'd1);
        check_cmd("post_rst", 0, 1'b1, 1'b0, 1'b1, 512'h636261, 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blake2s_msg_feeder.md
Name: blake2s_msg_feeder

Overview:
- Upstream stage of the BLAKE2s digest core: accepts a byte-serial message, packs it into 512-bit little-endian blocks, zero-pads the tail, and tracks the running byte count.
- Issues init/next/final commands to the core with the core_ready handshake.
- Guarantees the core sees the final flag on the correct block and never receives an empty trailing block, except for an empty message.

Parameters:
- BLOCK_BYTES, 64, bytes per compression block (fixed for BLAKE2s; kept as a parameter for sim only).
- LEN_W, 64, width of the byte counter t.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a message; accepted only in IDLE.
- msg_empty  in  1  sampled with start; 1 = zero-length message.
- in_valid  in  1  byte valid.
- in_data  in  8  message byte.
- in_last  in  1  qualifies the final byte of the message.
- in_ready  out  1  feeder accepts a byte this cycle.
- core_ready  in  1  core idle and able to take a command.
- core_init  out  1  one-cycle command pulse: first block.
- core_next  out  1  one-cycle command pulse: subsequent block.
- core_final  out  1  one-cycle flag, asserted together with init or next on the last block.
- core_block  out  512  block data; byte i at [8i+7:8i].
- core_length  out  LEN_W  total message bytes up to and including this block.
- busy  out  1  message in progress (not IDLE).

Behaviour:
- Reset values:
  - All outputs 0; block register, byte index and counter cleared; state IDLE.
  - Reset is honoured in any state, mid-message included; the partial message is discarded and no command is emitted.
- States: IDLE, FILL, ISSUE, GAP.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start with msg_empty=0 -> FILL with first_blk=1.
  - start with msg_empty=1 -> ISSUE with a zero block, length 0, last=1.
- FILL:
  - in_ready=1. On in_valid, the byte is written at index idx, idx increments and the counter increments by 1.
  - Go to ISSUE when idx reaches BLOCK_BYTES-1 on an accepted byte, or when an accepted byte has in_last=1.
  - The last flag is latched from in_last on that byte.
  - Unwritten bytes of the block are 0 (the register is cleared at each block start).
- ISSUE:
  - in_ready=0. core_block and core_length are held stable for the whole state.
  - When core_ready=1, pulse the command for exactly one cycle:
    - first_blk=1 -> core_init;
    - otherwise -> core_next;
    - core_final=last.
  - Then clear first_blk and idx and go to GAP.
  - While core_ready=0, wait indefinitely; no pulse is emitted.
- GAP:
  - Single cycle in which core_ready is ignored, covering the core's ready-drop latency.
  - Next state: IDLE if last, else FILL.
- Command latency: first command pulse occurs at the earliest 1 cycle after the byte that completes the block.
- Block boundary: the 64th byte arriving with in_last=1 produces exactly one block with final; no extra empty block follows.
- start outside IDLE is ignored. in_last on a byte not accepted (in_ready=0) has no effect.
- Counter arithmetic is modulo 2^LEN_W; wrap is not reachable in practice and raises no flag.

Optional Feature:
- Macro: BLAKE2_FEEDER_KEY_EN.
- Enabled:
  - Adds input ports key (256 bits) and key_len (6 bits), both sampled with start.
  - If key_len is nonzero, the first block issued is the key, zero-padded to 64 bytes, with core_length=64, sent via core_init.
  - Message bytes then follow as next blocks, with the counter continuing from 64.
  - Keyed empty message: the key block carries core_final=1.
  - key_len values greater than 32 are clamped to 32.
- Disabled: the key and key_len ports are absent; behaviour is exactly as above.

Decomposition:
- Shared package blake2s_pkg holds:
  - BLOCK_BYTES, BLOCK_W=512, LEN_W;
  - the feeder state enum;
  - a command struct {init, next, final, block, length}, shared with the core wrapper.
- One sub-module is natural: blake2s_block_buf, the 64-byte register with indexed byte write, clear, and full/idx outputs.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) -> one pulse with core_init=1 and core_final=1; core_length=3; core_block[23:0]=0x636261; all other bits 0.
- 64 bytes 0x00..0x3F, last on byte 63 -> single init+final pulse, length 64; no second command.
- 65 bytes -> init (final=0, length 64), then next+final with length 65 and core_block[7:0]=byte 64, rest 0.
- start with msg_empty=1 -> single init+final pulse, length 0, all-zero block; then IDLE with busy=0.
- Hold core_ready=0 for 10 cycles in ISSUE:
  - no pulse is emitted; in_ready=0;
  - block and length are stable;
  - the pulse occurs on the first cycle core_ready=1.
- Assert reset_n=0 after 30 bytes of a message -> all outputs 0 immediately; a following "abc" message yields length 3 with no stale bytes.
